// File: rtl/fetch_ctrl_pkg.sv
// Shared pipeline defines for the fetch sequencing controller: next-PC select
// encodings, mult/div busy FSM states and the default unit latencies.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_RS  = 2'b10,
    PC_J   = 2'b11
  } pcsel_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;
  localparam int CNT_W_DEF    = 16;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Pipeline-side bundle seen by the fetch controller: ID/EX/MEM hazard sources,
// mult/div issue, and the IFU select / stall / flush / status outputs.
interface fetch_ctrl_if #(parameter int CNT_W = 16);
  logic             IdBranch, IdTaken, IdJr, IdJump;
  logic [4:0]       IdRs, IdRt;
  logic             IdUseRs, IdUseRt, IdUseHiLo;
  logic             ExMemRead, ExRegWrite;
  logic [4:0]       ExWa;
  logic             MemMemRead;
  logic [4:0]       MemWa;
  logic             MdStart, MdIsDiv;
  logic [1:0]       PCControl;
  logic             stall, FlushId, MdBusy;
  logic [CNT_W-1:0] StallCycles;

  modport master (
    output IdBranch, IdTaken, IdJr, IdJump, IdRs, IdRt, IdUseRs, IdUseRt,
           IdUseHiLo, ExMemRead, ExRegWrite, ExWa, MemMemRead, MemWa,
           MdStart, MdIsDiv,
    input  PCControl, stall, FlushId, MdBusy, StallCycles
  );

  modport slave (
    input  IdBranch, IdTaken, IdJr, IdJump, IdRs, IdRt, IdUseRs, IdUseRt,
           IdUseHiLo, ExMemRead, ExRegWrite, ExWa, MemMemRead, MemWa,
           MdStart, MdIsDiv,
    output PCControl, stall, FlushId, MdBusy, StallCycles
  );
endinterface

// File: rtl/fetch_ctrl_md_busy_fsm.sv
// HI/LO unit occupancy tracker: IDLE/BUSY state plus a latency down-counter.
// A new mult/div issued while busy restarts the count (newest op wins).
module md_busy_fsm
  import fetch_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic Clk,
  input  logic Clr,
  input  logic MdStart,
  input  logic MdIsDiv,
  output logic MdBusy
);
  localparam int            LW    = $clog2(max_i(MULT_LAT, DIV_LAT) + 1);
  localparam logic [LW-1:0] MUL_L = LW'(MULT_LAT);
  localparam logic [LW-1:0] DIV_L = LW'(DIV_LAT);

  md_state_e     state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d, lat;

  assign lat = MdIsDiv ? DIV_L : MUL_L;

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (MdStart) begin
          state_d = MD_BUSY;
          cnt_d   = lat;
        end
      end
      MD_BUSY: begin
        if (MdStart) begin
          cnt_d = lat;
        end else if (cnt_q == LW'(1)) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - LW'(1);
        end
      end
    endcase
  end

  assign MdBusy = (state_q == MD_BUSY);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencing controller: GPR/HI-LO hazard detection, stall, next-PC select
// and IF/ID flush. Define BRANCH_FLUSH_EN to squash the slot after a redirect.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic Clk,
  input  logic Clr,
  fetch_ctrl_if.slave bus
);
  logic             md_busy;
  logic             ex_hit, mem_hit, redir_op;
  logic             gpr_haz, hilo_haz, stall_c, flush_c;
  pcsel_e           pc_sel;
  logic [CNT_W-1:0] stall_cnt_q;

  md_busy_fsm #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) u_md (
    .Clk     (Clk),
    .Clr     (Clr),
    .MdStart (bus.MdStart),
    .MdIsDiv (bus.MdIsDiv),
    .MdBusy  (md_busy)
  );

  // $zero is never a real dependency, so it cannot create a hazard.
  function automatic logic src_hit(input logic [4:0] src, input logic use_src,
                                   input logic [4:0] wa);
    return use_src && (src != 5'd0) && (src == wa);
  endfunction

  assign ex_hit   = src_hit(bus.IdRs, bus.IdUseRs, bus.ExWa)
                  | src_hit(bus.IdRt, bus.IdUseRt, bus.ExWa);
  assign mem_hit  = src_hit(bus.IdRs, bus.IdUseRs, bus.MemWa)
                  | src_hit(bus.IdRt, bus.IdUseRt, bus.MemWa);
  assign redir_op = bus.IdBranch | bus.IdJr;

  // Branch/jr operands are consumed in ID, so even an EX ALU result or a MEM load is too late.
  assign gpr_haz  = (ex_hit & (bus.ExMemRead | (redir_op & bus.ExRegWrite)))
                  | (mem_hit & redir_op & bus.MemMemRead);
  assign hilo_haz = bus.IdUseHiLo & (md_busy | bus.MdStart);
  assign stall_c  = Clr & (gpr_haz | hilo_haz);

  always_comb begin
    pc_sel = PC_SEQ;
    if (Clr && !stall_c) begin
      if (bus.IdJump)                     pc_sel = PC_J;
      else if (bus.IdJr)                  pc_sel = PC_RS;
      else if (bus.IdBranch && bus.IdTaken) pc_sel = PC_BR;
    end
  end

`ifdef BRANCH_FLUSH_EN
  assign flush_c = Clr & ~stall_c
                 & (bus.IdJump | bus.IdJr | (bus.IdBranch & bus.IdTaken));
`else
  assign flush_c = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr)
      stall_cnt_q <= '0;
    else if (stall_c && (stall_cnt_q != '1))
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
  end

  assign bus.PCControl   = pc_sel;
  assign bus.stall       = stall_c;
  assign bus.FlushId     = flush_c;
  assign bus.MdBusy      = md_busy;
  assign bus.StallCycles = stall_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: expectations are queued per step and popped
// against the DUT outputs. Narrow counter width keeps the saturation run short.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic Clk = 1'b0;
  logic Clr;

  fetch_ctrl_if #(.CNT_W(CW)) bus ();

  fetch_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(CW)) dut (
    .Clk (Clk),
    .Clr (Clr),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   sc    = 0;   // model of StallCycles

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sbq.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sbq.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: got %0h, nothing expected", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.val) else begin
        n_bad++;
        $error("FAIL %s: got %0h want %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic idle();
    bus.IdBranch = 0; bus.IdTaken = 0; bus.IdJr = 0; bus.IdJump = 0;
    bus.IdRs = 0; bus.IdRt = 0; bus.IdUseRs = 0; bus.IdUseRt = 0;
    bus.IdUseHiLo = 0; bus.ExMemRead = 0; bus.ExRegWrite = 0; bus.ExWa = 0;
    bus.MemMemRead = 0; bus.MemWa = 0; bus.MdStart = 0; bus.MdIsDiv = 0;
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  // Queue expectations for this step, let inputs settle, then compare.
  task automatic check(input string tag, input logic st, input logic [1:0] pc,
                       input logic busy);
    logic fl;
`ifdef BRANCH_FLUSH_EN
    fl = (pc != 2'b00);
`else
    fl = 1'b0;
`endif
    push({tag, ".stall"}, 32'(st));
    push({tag, ".pc"},    32'(pc));
    push({tag, ".flush"}, 32'(fl));
    push({tag, ".busy"},  32'(busy));
    push({tag, ".cnt"},   32'(sc));
    #3;
    pop_cmp(32'(bus.stall));
    pop_cmp(32'(bus.PCControl));
    pop_cmp(32'(bus.FlushId));
    pop_cmp(32'(bus.MdBusy));
    pop_cmp(32'(bus.StallCycles));
    if (Clr === 1'b1 && st) sc = (sc >= CMAX) ? CMAX : sc + 1;
  endtask

  initial begin
    Clr = 1'b0;
    idle();
    // Hazard-causing inputs while in reset must not leak to outputs.
    bus.MdStart = 1; bus.MdIsDiv = 1; bus.IdUseHiLo = 1; bus.IdJump = 1;
    bus.ExMemRead = 1; bus.ExWa = 8; bus.IdRs = 8; bus.IdUseRs = 1;
    check("reset", 0, 2'b00, 0);
    cyc();
    check("reset_edge", 0, 2'b00, 0);
    idle();
    @(negedge Clk);
    Clr = 1'b1;

    cyc(); check("idle", 0, 2'b00, 0);

    cyc(); bus.ExMemRead = 1; bus.ExWa = 8; bus.IdRs = 8; bus.IdUseRs = 1;
    check("load_use", 1, 2'b00, 0);
    cyc(); idle();
    check("load_use_clear", 0, 2'b00, 0);

    cyc(); bus.IdBranch = 1; bus.IdTaken = 1;
    check("br_taken", 0, 2'b01, 0);
    cyc(); bus.IdTaken = 0;
    check("br_not_taken", 0, 2'b00, 0);

    cyc(); idle(); bus.ExRegWrite = 1; bus.ExWa = 3; bus.IdBranch = 1;
    bus.IdTaken = 1; bus.IdRt = 3; bus.IdUseRt = 1;
    check("br_alu_dep", 1, 2'b00, 0);
    cyc(); bus.ExRegWrite = 0;
    check("br_alu_clear", 0, 2'b01, 0);

    cyc(); idle(); bus.ExRegWrite = 1; bus.ExWa = 3; bus.IdRt = 3; bus.IdUseRt = 1;
    check("alu_no_branch", 0, 2'b00, 0);

    cyc(); idle(); bus.IdJr = 1; bus.IdUseRs = 1; bus.IdRs = 5;
    bus.MemMemRead = 1; bus.MemWa = 5;
    check("jr_mem_load", 1, 2'b00, 0);
    cyc(); bus.MemMemRead = 0;
    check("jr_clear", 0, 2'b10, 0);

    cyc(); idle(); bus.IdJump = 1; bus.IdJr = 1; bus.IdBranch = 1; bus.IdTaken = 1;
    check("prio_jump", 0, 2'b11, 0);
    cyc(); bus.IdJump = 0;
    check("prio_jr", 0, 2'b10, 0);

    cyc(); idle(); bus.ExMemRead = 1; bus.ExWa = 0; bus.IdRs = 0; bus.IdUseRs = 1;
    check("zero_reg", 0, 2'b00, 0);
    cyc(); bus.ExWa = 8; bus.IdRs = 8; bus.IdUseRs = 0;
    check("unused_src", 0, 2'b00, 0);

    // Divide: stall on the issue cycle plus 10 busy cycles; jump deferred.
    cyc(); idle(); bus.MdStart = 1; bus.MdIsDiv = 1; bus.IdUseHiLo = 1; bus.IdJump = 1;
    check("div_start", 1, 2'b00, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(); bus.MdStart = 0;
      check("div_busy", 1, 2'b00, 1);
    end
    cyc(); check("div_done", 0, 2'b11, 0);

    // Multiply reissued while busy restarts the 5-cycle count.
    cyc(); idle(); bus.MdStart = 1;
    check("mul_start", 0, 2'b00, 0);
    cyc(); bus.MdStart = 0;
    check("mul_busy1", 0, 2'b00, 1);
    cyc(); bus.MdStart = 1;
    check("mul_reload", 0, 2'b00, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(); bus.MdStart = 0;
      check("mul_after_reload", 0, 2'b00, 1);
    end
    cyc(); check("mul_done", 0, 2'b00, 0);

    // Hold a load-use stall until the counter saturates, then beyond.
    cyc(); idle(); bus.ExMemRead = 1; bus.ExWa = 9; bus.IdRt = 9; bus.IdUseRt = 1;
    for (int k = 0; k < 400 && sc < CMAX; k++) begin
      check("sat_ramp", 1, 2'b00, 0);
      cyc();
    end
    for (int k = 0; k < 3; k++) begin
      check("sat_hold", 1, 2'b00, 0);
      cyc();
    end
    idle();
    check("sat_idle", 0, 2'b00, 0);

    // Asynchronous reset in the middle of a divide.
    cyc(); bus.MdStart = 1; bus.MdIsDiv = 1; bus.IdUseHiLo = 1;
    check("rdiv_start", 1, 2'b00, 0);
    cyc(); bus.MdStart = 0;
    check("rdiv_busy1", 1, 2'b00, 1);
    cyc(); check("rdiv_busy2", 1, 2'b00, 1);
    #1;
    Clr = 1'b0;
    sc  = 0;
    check("rst_async", 0, 2'b00, 0);
    cyc(); bus.MdStart = 1;
    check("rst_hold", 0, 2'b00, 0);
    idle();
    @(negedge Clk);
    Clr = 1'b1;
    cyc(); check("post_rst", 0, 2'b00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencing controller for the instruction-fetch unit of the 5-stage MIPS pipeline.
- Decides each cycle whether the PC register advances, redirects (branch / jr / jump) or holds.
- Drives the IFU PCControl select and stall inputs, plus the IF/ID flush.
- Contains the load-use / branch-operand hazard detector and the multi-cycle mult/div busy FSM that freezes fetch.

Parameters:
- MULT_LAT, 5: cycles a MULT/MULTU occupies the HI/LO unit.
- DIV_LAT, 10: cycles a DIV/DIVU occupies the HI/LO unit.
- CNT_W, 16: width of the saturating stall-cycle counter.

Ports:
- Clk  in  1  system clock, rising edge.
- Clr  in  1  reset; asynchronous, active-low.
- IdBranch  in  1  ID holds a conditional branch.
- IdTaken  in  1  branch condition true (ID comparator); valid with IdBranch.
- IdJr  in  1  ID holds JR/JALR (target on IFU Rdata).
- IdJump  in  1  ID holds J/JAL (target on IFU Ldata).
- IdRs, IdRt  in  5 each  source registers of ID instruction.
- IdUseRs, IdUseRt  in  1 each  ID instruction reads that source.
- IdUseHiLo  in  1  ID holds MFHI/MFLO/MTHI/MTLO/MULT/DIV.
- ExMemRead  in  1  EX holds a load.
- ExRegWrite  in  1  EX writes the GPR file.
- ExWa  in  5  EX destination register.
- MemMemRead  in  1  MEM holds a load.
- MemWa  in  5  MEM destination register.
- MdStart  in  1  EX issues mult/div this cycle.
- MdIsDiv  in  1  qualifies MdStart: 1 = divide latency.
- PCControl  out  2  IFU next-PC select: 00 = PC+4, 01 = branch, 10 = Rdata, 11 = Ldata.
- stall  out  1  freeze PC and IF/ID; insert bubble into EX.
- FlushId  out  1  clear IF/ID on next edge.
- MdBusy  out  1  HI/LO unit busy.
- StallCycles  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset (Clr=0, async): MD FSM to IDLE, latency counter 0, StallCycles 0. All outputs 0 while in reset.
- GPR hazard is combinational and only for source registers ≠ 0. It asserts when any of the following holds:
  - load-use: ExMemRead and ExWa matches a used source;
  - branch/jr operand pending from an EX ALU result: (IdBranch|IdJr) and ExRegWrite and ExWa matches a used source;
  - branch/jr operand pending from a load in MEM: (IdBranch|IdJr) and MemMemRead and MemWa matches a used source.
- MD FSM states:
  - IDLE: MdStart loads counter with DIV_LAT if MdIsDiv else MULT_LAT, then → BUSY.
  - BUSY: counter decrements each cycle; when counter==1 → IDLE next edge.
  - MdStart while BUSY reloads the counter with the new latency (newest op wins); stays BUSY.
- MdBusy = (state==BUSY). It is registered, so it rises 1 cycle after MdStart.
- HI/LO hazard: IdUseHiLo and (MdBusy or MdStart).
- stall = GPR hazard | HI/LO hazard. Combinational, same cycle as inputs.
- PCControl when stall=1: forced 00 (redirect deferred until the hazard clears).
- PCControl when stall=0, priority order:
  - IdJump → 11;
  - else IdJr → 10;
  - else IdBranch&IdTaken → 01;
  - else 00.
- Simultaneous redirect flags are a decode error; the priority above resolves them deterministically.
- FlushId: 0 in base configuration (delay-slot semantics; the slot instruction always executes).
- StallCycles: +1 on each edge with stall=1; holds at all-ones.
- Reset mid-operation: BUSY aborts immediately and stall drops.

Optional Feature:
- Macro: BRANCH_FLUSH_EN.
- Defined: no delay slot. FlushId = ~stall & (IdJump | IdJr | (IdBranch&IdTaken)), same cycle as the redirect, squashing the fetched slot instruction.
- Undefined: FlushId tied 0; delay-slot architecture.

Decomposition:
- Shared package (pipeline defines file):
  - PCControl encodings PC_SEQ=2'b00, PC_BR=2'b01, PC_RS=2'b10, PC_J=2'b11;
  - MD FSM state codes MD_IDLE, MD_BUSY;
  - latency defaults.
- One sub-module, md_busy_fsm: the IDLE/BUSY state and latency counter, taking Clk, Clr, MdStart and MdIsDiv and producing MdBusy.
- Hazard and PCControl logic stay in fetch_ctrl.

Test Plan:
- Load-use: ExMemRead=1, ExWa=8, IdRs=8, IdUseRs=1 → stall=1, PCControl=00 for exactly 1 cycle; StallCycles 0→1.
- Taken branch: IdBranch=1, IdTaken=1, no hazard → PCControl=01, stall=0. With BRANCH_FLUSH_EN, FlushId=1 as well.
- Branch after ALU write: ExRegWrite=1, ExWa=3, IdBranch=1, IdRt=3 → stall=1, PCControl=00. Next cycle (hazard gone) → PCControl=01.
- Divide: MdStart=1, MdIsDiv=1, then IdUseHiLo=1 held → stall=1 for the MdStart cycle plus 10 busy cycles, MdBusy high 10 cycles, then stall=0.
- Zero register: ExMemRead=1, ExWa=0, IdRs=0 → stall=0. StallCycles at 16'hFFFF stays 16'hFFFF under stall.
- Async reset during BUSY with DIV: Clr low mid-count → MdBusy=0, stall=0, StallCycles=0 immediately, without a clock edge.
